// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU plus single-cycle MTHI/MTLO.
// Raises stall while an iterative op is in flight and the current instruction touches HI/LO.
module hilo_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hi_w,
   input  logic             lo_w,
   input  logic [1:0]       hi_src,
   input  logic [1:0]       lo_src,
   input  logic             unsigned_instr,
   input  logic             hilo_rd,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             busy,
   output logic             stall
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   op_a_q, op_b_q, hi_q, lo_q;
   logic [2*WIDTH-1:0] acc_q;
   logic               neg_p_q, neg_r_q, div_zero_q;
   logic               busy_int;

   logic               start_mul, start_div, do_mthi, do_mtlo, last;
   logic               rs_neg, rt_neg;
   logic [WIDTH-1:0]   rs_abs, rt_abs;
   logic [WIDTH:0]     mul_sum, div_sh, div_diff;
   logic [2*WIDTH-1:0] mul_next, prod_fin;
   logic [WIDTH-1:0]   rem_next, quo_next, rem_fin, quo_fin;

   assign start_mul = hi_w & lo_w & (hi_src == 2'b01) & ~busy_int;
   assign start_div = hi_w & lo_w & (hi_src == 2'b10) & ~busy_int;
   assign do_mthi   = hi_w & ~lo_w & (hi_src == 2'b00) & ~busy_int;
   assign do_mtlo   = lo_w & ~hi_w & (lo_src == 2'b00) & ~busy_int;
   assign last      = (cnt_q == LAST);

   assign rs_neg = ~unsigned_instr & rs_data[WIDTH-1];
   assign rt_neg = ~unsigned_instr & rt_data[WIDTH-1];
   assign rs_abs = rs_neg ? -rs_data : rs_data;
   assign rt_abs = rt_neg ? -rt_data : rt_data;

   // Multiply: upper half holds the running partial sum, finished low bits shift in from the top.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{op_b_q[0]}} & op_a_q};
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
   assign prod_fin = neg_p_q ? -mul_next : mul_next;

   // Restoring divide: acc = {remainder, quotient}; dividend bits stream out of op_a MSB-first.
   assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], op_a_q[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, op_b_q};
   assign rem_next = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
   assign quo_next = {acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
   assign rem_fin  = neg_r_q ? -rem_next : rem_next;
   assign quo_fin  = div_zero_q ? {WIDTH{1'b1}} : (neg_p_q ? -quo_next : quo_next);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_mul)      state_d = S_MUL;
            else if (start_div) state_d = S_DIV;
         end
         S_MUL, S_DIV: if (last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_int = 1'b0;
      if (state_q != S_IDLE) busy_int = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         acc_q      <= '0;
         neg_p_q    <= 1'b0;
         neg_r_q    <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_mul || start_div) begin
                  op_a_q     <= rs_abs;
                  op_b_q     <= rt_abs;
                  acc_q      <= '0;
                  cnt_q      <= '0;
                  neg_p_q    <= rs_neg ^ rt_neg;
                  neg_r_q    <= rs_neg;
                  div_zero_q <= (rt_data == '0);
               end
               if (do_mthi) hi_q <= rs_data;
               if (do_mtlo) lo_q <= rs_data;
            end
            S_MUL: begin
               acc_q  <= mul_next;
               op_b_q <= op_b_q >> 1;
               cnt_q  <= cnt_q + 1'b1;
               if (last) {hi_q, lo_q} <= prod_fin;
            end
            S_DIV: begin
               acc_q  <= {rem_next, quo_next};
               op_a_q <= op_a_q << 1;
               cnt_q  <= cnt_q + 1'b1;
               if (last) begin
                  hi_q <= rem_fin;
                  lo_q <= quo_fin;
               end
            end
            default: ;
         endcase
      end
   end

   // stall is the "not ready" side: while high the presented instruction is held and re-presented
   // next cycle; it drops in the cycle busy falls, when HI/LO already hold the new result.
   assign stall  = busy_int & (hi_w | lo_w | hilo_rd);
   assign busy   = busy_int;
   assign hi_out = hi_q;
   assign lo_out = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed vector table, random ops against an arithmetic model,
// and hand sequences for stall/hazard ordering and mid-operation reset.
module tb_hilo_muldiv_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         hi_w, lo_w, unsigned_instr, hilo_rd;
   logic [1:0]   hi_src, lo_src;
   logic [W-1:0] rs_data, rt_data, hi_out, lo_out;
   logic         busy, stall;

   int errors = 0;
   int checks = 0;
   logic [2*W-1:0] exp_q[$];

   typedef struct {
      bit           is_div;
      bit           uns;
      logic [W-1:0] rs;
      logic [W-1:0] rt;
      logic [W-1:0] exp_hi;
      logic [W-1:0] exp_lo;
   } vec_t;

   vec_t vecs[7];

   hilo_muldiv_unit #(.WIDTH(W), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .hi_w(hi_w), .lo_w(lo_w), .hi_src(hi_src), .lo_src(lo_src),
      .unsigned_instr(unsigned_instr), .hilo_rd(hilo_rd), .rs_data(rs_data), .rt_data(rt_data),
      .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .stall(stall)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_idle();
      hi_w = 0; lo_w = 0; hi_src = 0; lo_src = 0; unsigned_instr = 0; hilo_rd = 0;
      rs_data = 0; rt_data = 0;
   endtask

   // Presents a MULT/DIV for one cycle; called and returns at a falling edge.
   task automatic start_op(input bit is_div, input bit uns, input logic [W-1:0] a, input logic [W-1:0] b);
      hi_w = 1; lo_w = 1; hi_src = is_div ? 2'b10 : 2'b01; lo_src = hi_src;
      unsigned_instr = uns; rs_data = a; rt_data = b; hilo_rd = 0;
      #1 chk("start_not_stalled", {31'b0, stall}, 0);
      @(negedge clk);
      set_idle();
   endtask

   task automatic wait_done(output int n);
      n = 0;
      #1;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
   endtask

   function automatic logic [2*W-1:0] ref_model(input bit is_div, input bit uns,
                                                 input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, q, r;
      longint unsigned ua, ub;
      if (!is_div) begin
         if (uns) begin
            ua = a; ub = b;
            return ua * ub;
         end
         sa = $signed(a); sb = $signed(b);
         return sa * sb;
      end
      if (b == 0) return {a, {W{1'b1}}};
      if (uns) return {a % b, a / b};
      sa = $signed(a); sb = $signed(b);
      q = sa / sb; r = sa % sb;
      return {r[W-1:0], q[W-1:0]};
   endfunction

   initial begin
      int n;
      logic [2*W-1:0] e;
      logic [W-1:0] a, b;
      bit dv, us;

      vecs[0] = '{0, 0, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[1] = '{0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[2] = '{0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1};
      vecs[3] = '{1, 0, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[4] = '{1, 1, 32'd100,      32'd7,        32'd2,        32'd14};
      vecs[5] = '{1, 1, 32'h1234,     32'h0,        32'h1234,     32'hFFFFFFFF};
      vecs[6] = '{1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000};

      set_idle();
      rst_n = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_hi", hi_out, 0);
      chk("reset_lo", lo_out, 0);
      chk("reset_busy", {31'b0, busy}, 0);
      chk("reset_stall", {31'b0, stall}, 0);
      rst_n = 1;
      @(negedge clk);

      // Single-cycle moves and ignored encodings
      hi_w = 1; hi_src = 2'b00; rs_data = 32'hA5A50001;
      @(negedge clk); set_idle(); #1;
      chk("mthi_hi", hi_out, 32'hA5A50001);
      chk("mthi_lo", lo_out, 0);
      lo_w = 1; lo_src = 2'b00; rs_data = 32'h00005A5A;
      @(negedge clk); set_idle(); #1;
      chk("mtlo_lo", lo_out, 32'h00005A5A);
      chk("mtlo_hi", hi_out, 32'hA5A50001);
      hi_w = 1; hi_src = 2'b11; rs_data = 32'hDEADBEEF;
      @(negedge clk); set_idle();
      lo_w = 1; lo_src = 2'b11; rs_data = 32'hDEADBEEF;
      @(negedge clk); set_idle();
      hi_w = 1; lo_w = 1; hi_src = 2'b00; lo_src = 2'b00; rs_data = 32'hDEADBEEF;
      @(negedge clk); set_idle();
      hi_w = 1; lo_w = 1; hi_src = 2'b11; lo_src = 2'b01; rs_data = 32'hDEADBEEF; rt_data = 3;
      @(negedge clk); set_idle(); #1;
      chk("ignored_hi", hi_out, 32'hA5A50001);
      chk("ignored_lo", lo_out, 32'h00005A5A);
      chk("ignored_busy", {31'b0, busy}, 0);

      // Directed table
      for (int i = 0; i < 7; i++) begin
         start_op(vecs[i].is_div, vecs[i].uns, vecs[i].rs, vecs[i].rt);
         wait_done(n);
         chk($sformatf("vec%0d_latency", i), n, 32);
         chk($sformatf("vec%0d_hi", i), hi_out, vecs[i].exp_hi);
         chk($sformatf("vec%0d_lo", i), lo_out, vecs[i].exp_lo);
         @(negedge clk);
      end

      // Random ops against the arithmetic model
      for (int i = 0; i < 24; i++) begin
         dv = $urandom_range(0, 1);
         us = $urandom_range(0, 1);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 40); end
            3: b = $urandom_range(1, 9);
            default: ;
         endcase
         exp_q.push_back(ref_model(dv, us, a, b));
         start_op(dv, us, a, b);
         wait_done(n);
         e = exp_q.pop_front();
         chk($sformatf("rnd%0d_latency", i), n, 32);
         chk($sformatf("rnd%0d_hi div=%0d u=%0d a=%h b=%h", i, dv, us, a, b), hi_out, e[2*W-1:W]);
         chk($sformatf("rnd%0d_lo div=%0d u=%0d a=%h b=%h", i, dv, us, a, b), lo_out, e[W-1:0]);
         @(negedge clk);
      end

      // Hazards during MULT: MFHI stalls, unrelated op does not, MTHI waits for the result
      start_op(0, 0, 32'hFFFFFFFD, 32'h5);
      repeat (2) @(negedge clk);
      hilo_rd = 1;
      #1 chk("mfhi_stall", {31'b0, stall}, 1);
      @(negedge clk); set_idle();
      #1 chk("unrelated_no_stall", {31'b0, stall}, 0);
      @(negedge clk);
      hi_w = 1; hi_src = 2'b00; rs_data = 32'h13579BDF;
      n = 5;
      forever begin
         #1;
         if (stall !== 1'b1 || n >= 100) break;
         @(negedge clk);
         n++;
      end
      chk("mthi_stall_end_cycle", n, 33);
      chk("mthi_wait_busy", {31'b0, busy}, 0);
      chk("mthi_wait_hi_is_product", hi_out, 32'hFFFFFFFF);
      chk("mthi_wait_lo_is_product", lo_out, 32'hFFFFFFF1);
      @(negedge clk); set_idle(); #1;
      chk("mthi_after_hi", hi_out, 32'h13579BDF);
      chk("mthi_after_lo", lo_out, 32'hFFFFFFF1);

      // Reset in the middle of a DIV
      @(negedge clk);
      start_op(1, 0, 32'hFFFFFFF9, 32'h2);
      repeat (9) @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("midreset_busy", {31'b0, busy}, 0);
      chk("midreset_hi", hi_out, 0);
      chk("midreset_lo", lo_out, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (40) @(negedge clk);
      #1;
      chk("postreset_hi", hi_out, 0);
      chk("postreset_lo", lo_out, 0);
      @(negedge clk);
      start_op(0, 1, 32'd6, 32'd7);
      wait_done(n);
      chk("multu_after_reset_latency", n, 32);
      chk("multu_after_reset_hi", hi_out, 0);
      chk("multu_after_reset_lo", lo_out, 32'd42);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
